// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among eight requesters.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   en       - arbiter enable; low releases the current grant and blocks new ones
//   req      - request vector, bit i belongs to mux input i
//   gnt      - registered one-hot grant, zero when idle
//   sel      - registered mux select, index of current or last owner
//   busy     - registered, high while a grant is active
//   hold_cnt - cycles the current owner has held the mux, saturating at MAX_HOLD
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       req,
  output logic [7:0]       gnt,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam int unsigned     N_REQ    = 8;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n;
  logic [7:0]       gnt_n;
  logic [2:0]       sel_n;
  logic             busy_n;
  logic [CNT_W-1:0] hold_n;

  // First set bit of r scanning cyclically upward from start.
  function automatic logic [2:0] rr_pick(input logic [2:0] start, input logic [7:0] r);
    logic [2:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = 3'(start + 3'(k));
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      gnt      <= 8'h00;
      sel      <= 3'd0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      busy     <= busy_n;
      hold_cnt <= hold_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    logic [2:0] w;
    logic [2:0] nptr;
    logic       release_now;

    state_n     = state;
    ptr_n       = ptr;
    gnt_n       = gnt;
    sel_n       = sel;
    hold_n      = hold_cnt;
    w           = 3'd0;
    nptr        = 3'(sel + 3'd1);
    release_now = 1'b0;

    unique case (state)
      IDLE: begin
        if (en && (req != 8'h00)) begin
          w       = rr_pick(ptr, req);
          gnt_n   = 8'h01 << w;
          sel_n   = w;
          hold_n  = HOLD_ONE;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // sel is the owner index while granted
        release_now = !req[sel] || !en ||
                      ((hold_cnt == HOLD_MAX) && ((req & ~(8'h01 << sel)) != 8'h00));
        if (!release_now) begin
          if (hold_cnt != HOLD_MAX) hold_n = hold_cnt + HOLD_ONE;
        end else begin
          // Starting the search at owner+1 places the owner's own request last.
          ptr_n = nptr;
          if (en && (req != 8'h00)) begin
            w      = rr_pick(nptr, req);
            gnt_n  = 8'h01 << w;
            sel_n  = w;
            hold_n = HOLD_ONE;
          end else begin
            gnt_n   = 8'h00;
            hold_n  = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (gnt_n != 8'h00);
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with hand-computed expectations.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic [2:0] hold_cnt;

  int n_vec;
  int n_miss;

  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .sel(sel), .busy(busy), .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'h00;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 8'hFF;
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || hold_cnt !== 3'd0) begin
      n_miss++;
      $display("FAIL reset_async: gnt=%h sel=%0d busy=%b hold=%0d, expected 00 0 0 0",
               gnt, sel, busy, hold_cnt);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1 || hold_cnt !== 3'd1) begin
      n_miss++;
      $display("FAIL reset_first_grant: gnt=%h sel=%0d busy=%b hold=%0d, expected 01 0 1 1",
               gnt, sel, busy, hold_cnt);
    end
  endtask

  task automatic test_lone_requester();
    logic [2:0] exp_h;
    do_reset();
    req = 8'b0000_0100;
    for (int c = 1; c <= 10; c++) begin
      step();
      exp_h = (c >= 4) ? 3'd4 : 3'(c);
      n_vec++;
      if (gnt !== 8'h04 || sel !== 3'd2 || busy !== 1'b1 || hold_cnt !== exp_h) begin
        n_miss++;
        $display("FAIL lone_hold cyc%0d: gnt=%h sel=%0d busy=%b hold=%0d, expected 04 2 1 %0d",
                 c, gnt, sel, busy, hold_cnt, exp_h);
      end
    end
    req = 8'h00;
    step();
    n_vec++;
    if (gnt !== 8'h00 || sel !== 3'd2 || busy !== 1'b0 || hold_cnt !== 3'd0) begin
      n_miss++;
      $display("FAIL lone_release: gnt=%h sel=%0d busy=%b hold=%0d, expected 00 2 0 0",
               gnt, sel, busy, hold_cnt);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_g;
    logic [2:0] exp_s;
    do_reset();
    req = 8'hFF;
    for (int i = 0; i <= 8; i++) begin
      for (int c = 1; c <= 4; c++) begin
        if (i < 8 || c == 1) begin
          step();
          exp_s = 3'(i % 8);
          exp_g = 8'h01 << exp_s;
          n_vec++;
          if (gnt !== exp_g || sel !== exp_s || busy !== 1'b1 || hold_cnt !== 3'(c)) begin
            n_miss++;
            $display("FAIL rotation owner%0d cyc%0d: gnt=%h sel=%0d busy=%b hold=%0d, expected %h %0d 1 %0d",
                     i, c, gnt, sel, busy, hold_cnt, exp_g, exp_s, c);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'b1000_0000;
    step();
    n_vec++;
    if (gnt !== 8'h80 || sel !== 3'd7 || hold_cnt !== 3'd1) begin
      n_miss++;
      $display("FAIL wrap_owner7: gnt=%h sel=%0d hold=%0d, expected 80 7 1", gnt, sel, hold_cnt);
    end
    req = 8'b1000_0001;
    step();
    step();
    step();
    n_vec++;
    if (gnt !== 8'h80 || hold_cnt !== 3'd4) begin
      n_miss++;
      $display("FAIL wrap_hold: gnt=%h hold=%0d, expected 80 4", gnt, hold_cnt);
    end
    step();
    n_vec++;
    if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1 || hold_cnt !== 3'd1) begin
      n_miss++;
      $display("FAIL wrap_to0: gnt=%h sel=%0d busy=%b hold=%0d, expected 01 0 1 1",
               gnt, sel, busy, hold_cnt);
    end
    req = 8'b1000_0000;
    step();
    n_vec++;
    if (gnt !== 8'h80 || sel !== 3'd7 || busy !== 1'b1 || hold_cnt !== 3'd1) begin
      n_miss++;
      $display("FAIL wrap_back7: gnt=%h sel=%0d busy=%b hold=%0d, expected 80 7 1 1",
               gnt, sel, busy, hold_cnt);
    end
  endtask

  task automatic test_enable();
    do_reset();
    req = 8'b0000_1000;
    step();
    n_vec++;
    if (gnt !== 8'h08 || sel !== 3'd3) begin
      n_miss++;
      $display("FAIL en_owner3: gnt=%h sel=%0d, expected 08 3", gnt, sel);
    end
    req = 8'hFF;
    en  = 1'b0;
    step();
    n_vec++;
    if (gnt !== 8'h00 || sel !== 3'd3 || busy !== 1'b0 || hold_cnt !== 3'd0) begin
      n_miss++;
      $display("FAIL en_drop: gnt=%h sel=%0d busy=%b hold=%0d, expected 00 3 0 0",
               gnt, sel, busy, hold_cnt);
    end
    step();
    n_vec++;
    if (gnt !== 8'h00 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL en_idle_ignore: gnt=%h busy=%b, expected 00 0", gnt, busy);
    end
    en  = 1'b1;
    req = 8'b0000_1001;
    step();
    n_vec++;
    if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1 || hold_cnt !== 3'd1) begin
      n_miss++;
      $display("FAIL en_resume_ptr: gnt=%h sel=%0d busy=%b hold=%0d, expected 01 0 1 1",
               gnt, sel, busy, hold_cnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'b0010_0000;
    step();
    n_vec++;
    if (gnt !== 8'h20 || sel !== 3'd5) begin
      n_miss++;
      $display("FAIL midrst_owner5: gnt=%h sel=%0d, expected 20 5", gnt, sel);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || hold_cnt !== 3'd0) begin
      n_miss++;
      $display("FAIL midrst_async: gnt=%h sel=%0d busy=%b hold=%0d, expected 00 0 0 0",
               gnt, sel, busy, hold_cnt);
    end
    req = 8'b0010_0010;
    #1 rst_n = 1'b1;
    step();
    n_vec++;
    if (gnt !== 8'h02 || sel !== 3'd1 || busy !== 1'b1 || hold_cnt !== 3'd1) begin
      n_miss++;
      $display("FAIL midrst_regrant: gnt=%h sel=%0d busy=%b hold=%0d, expected 02 1 1 1",
               gnt, sel, busy, hold_cnt);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b1;
    en     = 1'b0;
    req    = 8'h00;
    test_reset();
    test_lone_requester();
    test_rotation();
    test_wrap();
    test_enable();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares one MUX8_1 datapath among eight requesters. It drives the mux's 3-bit select (SEL) and a one-hot grant vector (GNT). Requester i owns mux input i while GNT[i]=1. A hold counter bounds how long one owner may keep the mux while others are waiting.

Parameters:
MAX_HOLD, 4, maximum consecutive grant cycles for one owner while other requests are pending; legal range 1..(2^CNT_W - 1)
CNT_W, 3, width of the hold counter and of HOLD_CNT

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
EN  input  1  arbiter enable; 0 = no new grants and the current grant is released
REQ  input  8  request vector, bit i = requester i (connected to mux input i)
GNT  output  8  one-hot grant, registered; all-zero when idle
SEL  output  3  MUX8_1 select = index of the current or last owner, registered
BUSY  output  1  1 while a grant is active (equals |GNT)
HOLD_CNT  output  CNT_W  cycles the current owner has held the grant, saturating at MAX_HOLD

Behaviour:
- Reset (RST_N=0, asynchronous, no clock needed):
  - GNT=0, SEL=0, BUSY=0, HOLD_CNT=0
  - state=IDLE, internal priority pointer PTR=0
- All outputs are registered. REQ and EN are sampled on the rising edge of CLK.
- Arbitration search: scan cyclically from PTR (PTR, PTR+1, ..., 7, 0, ...) and pick the first set bit of REQ. Index arithmetic is mod 8; PTR wraps 7 -> 0.
- State IDLE (GNT=0):
  - On an edge with EN=1 and REQ!=0, the search winner w is granted.
  - Next cycle: GNT=onehot(w), SEL=w, HOLD_CNT=1, state=GRANT.
  - Latency from REQ assertion to GNT is one edge.
  - Otherwise remain IDLE. SEL keeps its last value so the mux output stays stable.
- State GRANT (owner o). Release conditions, evaluated at each edge:
  - (a) REQ[o]=0
  - (b) EN=0
  - (c) HOLD_CNT==MAX_HOLD and (REQ & ~onehot(o))!=0, i.e. preemption
- If no release condition holds:
  - Keep the grant.
  - HOLD_CNT=min(HOLD_CNT+1, MAX_HOLD).
  - A lone requester therefore keeps the mux indefinitely.
- On release:
  - PTR=o+1 mod 8.
  - If EN=1 and the search from the new PTR finds a winner w (o's own REQ is considered last), grant w back-to-back on the same edge: GNT=onehot(w), SEL=w, HOLD_CNT=1. There is no idle bubble.
  - Otherwise GNT=0, BUSY=0, HOLD_CNT=0, state=IDLE, and SEL holds o.
- Condition (a) takes precedence over (c); both produce the same PTR update.
- EN=0 while IDLE: REQ is ignored and PTR is unchanged.
- GNT is never multi-hot. GNT!=0 implies SEL equals the index of its set bit.
- MAX_HOLD=1 gives strict per-cycle rotation among contending requesters.
- Reset asserted mid-grant: GNT clears immediately and PTR returns to 0. After reset release, the first grant goes to the lowest-index requester.

Test Plan:
1. Assert RST_N=0 with REQ=8'hFF, EN=1 -> GNT=8'h00, SEL=0, BUSY=0, HOLD_CNT=0 with no clock edge required. Release reset -> the next edge gives GNT=8'h01, SEL=0.
2. EN=1, REQ=8'b0000_0100 held 10 cycles -> GNT=8'h04 one edge after REQ, SEL=2, HOLD_CNT counts 1,2,3,4 and stays at 4, grant never dropped. Clear REQ -> next edge GNT=0, BUSY=0, SEL stays 2.
3. REQ=8'hFF constant, MAX_HOLD=4 -> GNT sequence 01,02,04,...,80,01, each held exactly 4 cycles. SEL steps 0..7,0. No cycle with GNT=0.
4. Wrap-around: owner 7 with REQ=8'b1000_0001 and HOLD_CNT reaching 4 -> next edge GNT=8'h01, SEL=0. Then owner 0 drops REQ -> GNT=8'h80.
5. Owner 3 granted, other REQ bits set, EN dropped -> next edge GNT=0. EN raised with REQ=8'b0000_1001 -> grant goes to 0, not 3 (search starts at PTR=4).
6. Owner 5 granted, RST_N pulsed low between edges -> GNT=0 asynchronously. After release with REQ=8'b0010_0010 -> GNT=8'h02.
